// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared encodings for the ADC capture engine.
//   MODE_*  : trigger-mode values presented on cfg_mode
//   state_t : capture FSM state encoding
package adc_capture_pkg;

  localparam logic [1:0] MODE_FREE = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;
  localparam logic [1:0] MODE_EXT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered (show-ahead) output stage.
// Capacity is DEPTH entries counting the output register, so "full" means
// DEPTH words are held in total. A write is accepted when full if the output
// word is consumed in the same cycle.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wr_en, wr_data        : write request and data
//   wr_accept             : write request taken this cycle
//   full, empty           : occupancy flags
//   rd_ready              : consumer ready (AXI-Stream style)
//   rd_valid, rd_data     : registered output word; held while not consumed
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_accept,
  output logic             full,
  output logic             empty,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             rd_fire, push, pop;

  assign rd_fire   = rd_valid & rd_ready;
  assign full      = (count + {{AW{1'b0}}, rd_valid}) == (AW+1)'(DEPTH);
  assign empty     = ~rd_valid;
  assign wr_accept = wr_en & (~full | rd_fire);
  assign push      = wr_accept;
  // refill the output register whenever it is empty or being drained
  assign pop       = (count != '0) & (~rd_valid | rd_fire);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/adc_capture_mc.sv
// adc_capture_mc: multi-channel ADC capture engine. Samples CHANNELS lanes on
// each adc_clk rising edge, decimates, waits for an armed trigger, then
// streams one FRAME_LEN-beat frame over AXI4-Stream through sync_fifo.
// Optional feature macro: ADC_CAPTURE_EXT_TRIG_EN enables the ext_trig
// synchroniser and mode 3; without it mode 3 acts as free-run.
// Ports:
//   axi_aclk, axi_areset  : clock, synchronous active-high reset
//   adc_clk, adc_data     : sample strobe and packed lanes
//   cfg_*                 : arm pulse, trigger mode/level/lane, decimation
//   ext_trig              : asynchronous external trigger
//   axis_*                : AXI4-Stream output (tdata = lanes, tlast = end of frame)
//   busy, done, overflow  : status (ARMED/CAPTURE, last beat written, sticky drop)
//
// state      | meaning
// ST_IDLE    | waiting for cfg_arm
// ST_ARMED   | evaluating kept samples against the trigger condition
// ST_CAPTURE | writing kept samples to the FIFO until the last beat
module adc_capture_mc
  import adc_capture_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DATA_W     = 8,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int DECIM_W    = 8,
  localparam int LW        = CHANNELS * DATA_W,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              adc_clk,
  input  logic [LW-1:0]     adc_data,
  input  logic              cfg_arm,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_level,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic              ext_trig,
  output logic              axis_tvalid,
  input  logic              axis_tready,
  output logic [LW-1:0]     axis_tdata,
  output logic              axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int BW = $clog2(FRAME_LEN);

  state_t              state, state_nxt;
  logic                clk_d, strobe, smp_stb, keep, trig, ext_hit;
  logic [LW-1:0]       smp;
  logic [DECIM_W-1:0]  dec_cnt;
  logic [DATA_W-1:0]   lane_val, prev;
  logic                prev_valid;
  logic [BW-1:0]       beat_cnt;
  logic                last_beat, arm_clr, wr_en, wr_accept;
  logic                unused_full, unused_empty;
  logic [LW:0]         fifo_out;

  assign strobe    = adc_clk & ~clk_d;
  assign keep      = smp_stb & (dec_cnt == '0);
  assign last_beat = beat_cnt == BW'(FRAME_LEN - 1);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    lane_val = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (cfg_chan == CH_W'(k)) lane_val = smp[k*DATA_W +: DATA_W];
  end

`ifdef ADC_CAPTURE_EXT_TRIG_EN
  logic ext_s1, ext_s2, ext_d, ext_seen;

  // an edge seen while armed stays latched until a later kept sample uses it
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      ext_d    <= 1'b0;
      ext_seen <= 1'b0;
    end else begin
      ext_s1 <= ext_trig;
      ext_s2 <= ext_s1;
      ext_d  <= ext_s2;
      if (arm_clr) ext_seen <= 1'b0;
      else if (state == ST_ARMED && ext_s2 && !ext_d) ext_seen <= 1'b1;
    end
  end
  assign ext_hit = ext_seen | (ext_s2 & ~ext_d);
`else
  logic unused_ext;
  assign unused_ext = ext_trig;
  assign ext_hit    = 1'b1;
`endif

  always_comb begin
    trig = 1'b0;
    case (cfg_mode)
      MODE_FREE: trig = 1'b1;
      MODE_RISE: trig = prev_valid && (prev <  cfg_level) && (lane_val >= cfg_level);
      MODE_FALL: trig = prev_valid && (prev >= cfg_level) && (lane_val <  cfg_level);
      MODE_EXT:  trig = ext_hit;
      default:   trig = 1'b0;
    endcase
  end

  assign wr_en = keep && ((state == ST_ARMED && trig) || state == ST_CAPTURE);

  always_comb begin
    state_nxt = state;
    arm_clr   = 1'b0;
    case (state)
      ST_IDLE: if (cfg_arm) begin
        state_nxt = ST_ARMED;
        arm_clr   = 1'b1;
      end
      // a dropped trigger beat still starts the frame; beat 0 is the next accepted sample
      ST_ARMED:   if (wr_en) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (wr_accept && last_beat) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      clk_d      <= 1'b0;
      smp_stb    <= 1'b0;
      smp        <= '0;
      dec_cnt    <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      beat_cnt   <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      clk_d   <= adc_clk;
      smp_stb <= strobe;
      if (strobe) smp <= adc_data;
      if (arm_clr) begin
        dec_cnt    <= '0;
        prev       <= '0;
        prev_valid <= 1'b0;
        beat_cnt   <= '0;
        overflow   <= 1'b0;
      end else begin
        if (smp_stb) dec_cnt <= (dec_cnt >= cfg_decim) ? '0 : dec_cnt + 1'b1;
        if (state == ST_ARMED && keep && !trig) begin
          prev       <= lane_val;
          prev_valid <= 1'b1;
        end
        if (wr_accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (wr_en && !wr_accept) overflow <= 1'b1;
      end
      done <= wr_accept & last_beat;
    end
  end

  sync_fifo #(
    .WIDTH (LW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (axi_aclk),
    .rst       (axi_areset),
    .wr_en     (wr_en),
    .wr_data   ({last_beat, smp}),
    .wr_accept (wr_accept),
    .full      (unused_full),
    .empty     (unused_empty),
    .rd_ready  (axis_tready),
    .rd_valid  (axis_tvalid),
    .rd_data   (fifo_out)
  );

  assign axis_tdata = fifo_out[LW-1:0];
  assign axis_tlast = fifo_out[LW];

endmodule

// File: tb/tb_adc_capture_mc.sv
module tb_adc_capture_mc;

  localparam int FL = 24;
  localparam int FD = 16;
  localparam int LW = 16;
  localparam int K_RAMP = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;

  logic          axi_aclk = 1'b0;
  logic          axi_areset = 1'b1;
  logic          adc_clk = 1'b0;
  logic [LW-1:0] adc_data = '0;
  logic          cfg_arm = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [7:0]    cfg_level = 8'd0;
  logic [0:0]    cfg_chan = 1'b0;
  logic [7:0]    cfg_decim = 8'd0;
  logic          ext_trig = 1'b0;
  logic          axis_tready = 1'b0;
  logic          axis_tvalid, axis_tlast, busy, done, overflow;
  logic [LW-1:0] axis_tdata;

  adc_capture_mc #(
    .CHANNELS(2), .DATA_W(8), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .DECIM_W(8)
  ) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset), .adc_clk(adc_clk), .adc_data(adc_data),
    .cfg_arm(cfg_arm), .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_chan(cfg_chan),
    .cfg_decim(cfg_decim), .ext_trig(ext_trig), .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready), .axis_tdata(axis_tdata), .axis_tlast(axis_tlast),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 axi_aclk = ~axi_aclk;

  int total = 0;
  int bad = 0;
  logic [15:0] got_data[$];
  logic        got_last[$];
  logic [15:0] smp_q[$];
  logic [15:0] exp_q[$];
  int  ndone = 0;
  bit  rnd_ready = 0;
  bit  stall_pend = 0;
  logic [16:0] stall_word;

  typedef struct {
    logic [1:0]  mode;
    int          decim;
    logic [7:0]  level;
    logic        chan;
    int          kind;
    int          n;
    logic [15:0] exp_first;
    logic [15:0] exp_final;
    int          exp_beats;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge axi_aclk) begin
    if (axi_areset) begin
      stall_pend = 0;
    end else begin
      if (stall_pend) begin
        check("hold tvalid", {31'd0, axis_tvalid}, 32'd1);
        check("hold tdata/tlast", {15'd0, axis_tlast, axis_tdata}, {15'd0, stall_word});
      end
      if (axis_tvalid && axis_tready) begin
        got_data.push_back(axis_tdata);
        got_last.push_back(axis_tlast);
      end
      if (done) ndone++;
      stall_pend = axis_tvalid && !axis_tready;
      stall_word = {axis_tlast, axis_tdata};
    end
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
    if (rnd_ready) axis_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic adc_sample(input logic [15:0] d);
    adc_data = d;
    adc_clk = 1'b1;
    tick(); tick();
    adc_clk = 1'b0;
    tick(); tick();
  endtask

  task automatic do_reset();
    axi_areset = 1'b1;
    adc_clk = 1'b0;
    cfg_arm = 1'b0;
    tick(); tick();
    axi_areset = 1'b0;
    got_data.delete();
    got_last.delete();
    ndone = 0;
  endtask

  task automatic arm();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  function automatic logic [15:0] gen(input int kind, input int i);
    logic [7:0] b, l;
    b = 8'(i);
    case (kind)
      K_RISE: begin
        case (i)
          0: l = 8'h10;
          1: l = 8'h7F;
          2: l = 8'h80;
          3: l = 8'h90;
          default: l = 8'(8'h90 + i);
        endcase
        return {l, b};
      end
      K_FALL: begin
        case (i)
          0: l = 8'h20;
          1: l = 8'h90;
          2: l = 8'hA0;
          3: l = 8'h30;
          default: l = b;
        endcase
        return {8'h55, l};
      end
      default: return {b, b};
    endcase
  endfunction

  // Reference: keep every (decim+1)-th sample after arm, find the first
  // trigger among kept samples, frame = next FL kept samples from there.
  task automatic build_expected(input logic [1:0] mode, input int decim,
                                input logic [7:0] level, input logic chan);
    logic [15:0] kept[$];
    logic [7:0]  v, prev;
    bit          have_prev, hit;
    int          trig;
    exp_q.delete();
    for (int i = 0; i < smp_q.size(); i++)
      if (i % (decim + 1) == 0) kept.push_back(smp_q[i]);
    trig = -1;
    have_prev = 0;
    prev = 8'd0;
    for (int j = 0; j < kept.size(); j++) begin
      v = chan ? kept[j][15:8] : kept[j][7:0];
      case (mode)
        2'd0: hit = 1;
        2'd1: hit = have_prev && (prev < level) && (v >= level);
        2'd2: hit = have_prev && (prev >= level) && (v < level);
        default: begin
`ifdef ADC_CAPTURE_EXT_TRIG_EN
          hit = 0;
`else
          hit = 1;
`endif
        end
      endcase
      if (hit) begin
        trig = j;
        break;
      end
      prev = v;
      have_prev = 1;
    end
    if (trig >= 0)
      for (int j = trig; j < kept.size() && exp_q.size() < FL; j++)
        exp_q.push_back(kept[j]);
  endtask

  task automatic run_frame(input logic [1:0] mode, input int decim,
                           input logic [7:0] level, input logic chan);
    int n, full;
    do_reset();
    cfg_mode = mode;
    cfg_decim = 8'(decim);
    cfg_level = level;
    cfg_chan = chan;
    rnd_ready = 1;
    arm();
    foreach (smp_q[i]) adc_sample(smp_q[i]);
    rnd_ready = 0;
    axis_tready = 1'b1;
    repeat (30) tick();
    build_expected(mode, decim, level, chan);
    full = (exp_q.size() == FL);
    check("beat count", got_data.size(), exp_q.size());
    n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("model beat", {16'd0, got_data[i]}, {16'd0, exp_q[i]});
      check("tlast position", {31'd0, got_last[i]}, (i == FL - 1) ? 32'd1 : 32'd0);
    end
    check("done count", ndone, full);
    check("busy after frame", {31'd0, busy}, full ? 32'd0 : 32'd1);
    check("no overflow", {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    int nb;
    vecs[0] = '{2'd0, 0, 8'h00, 1'b0, K_RAMP, 32, 16'h0000, 16'h1717, FL};
    vecs[1] = '{2'd1, 0, 8'h80, 1'b1, K_RISE, 40, 16'h8002, 16'hA919, FL};
    vecs[2] = '{2'd2, 0, 8'h80, 1'b0, K_FALL, 40, 16'h5530, 16'h551A, FL};
    vecs[3] = '{2'd0, 3, 8'h00, 1'b0, K_RAMP, 100, 16'h0000, 16'h5C5C, FL};
`ifdef ADC_CAPTURE_EXT_TRIG_EN
    vecs[4] = '{2'd3, 0, 8'h00, 1'b0, K_RAMP, 32, 16'h0000, 16'h0000, 0};
`else
    vecs[4] = '{2'd3, 0, 8'h00, 1'b0, K_RAMP, 32, 16'h0000, 16'h1717, FL};
`endif
    vecs[5] = '{2'd1, 1, 8'h05, 1'b0, K_RAMP, 60, 16'h0606, 16'h3434, FL};

    // reset state
    tick(); tick();
    check("reset tvalid", {31'd0, axis_tvalid}, 32'd0);
    check("reset tdata", {16'd0, axis_tdata}, 32'd0);
    check("reset tlast", {31'd0, axis_tlast}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    axi_areset = 1'b0;
    tick();

    // latency: strobe cycle t, tvalid first at t+3, held under backpressure
    do_reset();
    cfg_mode = 2'd0;
    cfg_decim = 8'd0;
    axis_tready = 1'b0;
    arm();
    adc_data = 16'hA55A;
    adc_clk = 1'b1;
    tick();
    check("latency t+1 tvalid", {31'd0, axis_tvalid}, 32'd0);
    tick();
    check("latency t+2 tvalid", {31'd0, axis_tvalid}, 32'd0);
    check("latency busy", {31'd0, busy}, 32'd1);
    tick();
    check("latency t+3 tvalid", {31'd0, axis_tvalid}, 32'd1);
    check("latency t+3 tdata", {16'd0, axis_tdata}, 32'h0000A55A);
    adc_clk = 1'b0;
    repeat (5) tick();
    check("stall tdata", {16'd0, axis_tdata}, 32'h0000A55A);

    // table-driven frames
    for (int r = 0; r < 6; r++) begin
      smp_q.delete();
      for (int i = 0; i < vecs[r].n; i++) smp_q.push_back(gen(vecs[r].kind, i));
      run_frame(vecs[r].mode, vecs[r].decim, vecs[r].level, vecs[r].chan);
      check("vec beats", got_data.size(), vecs[r].exp_beats);
      if (vecs[r].exp_beats > 0 && got_data.size() > 0) begin
        check("vec first beat", {16'd0, got_data[0]}, {16'd0, vecs[r].exp_first});
        check("vec final beat", {16'd0, got_data[got_data.size()-1]}, {16'd0, vecs[r].exp_final});
      end
    end

    // backpressure / overflow
    do_reset();
    cfg_mode = 2'd0;
    cfg_decim = 8'd0;
    axis_tready = 1'b0;
    arm();
    for (int i = 0; i < 40; i++) adc_sample({8'(i), 8'(i)});
    check("overflow set", {31'd0, overflow}, 32'd1);
    check("nothing drained", got_data.size(), 0);
    check("head tdata", {16'd0, axis_tdata}, 32'd0);
    axis_tready = 1'b1;
    repeat (30) tick();
    check("buffered beats", got_data.size(), FD);
    for (int i = 40; i < 50; i++) adc_sample({8'(i), 8'(i)});
    repeat (20) tick();
    check("ovf total beats", got_data.size(), FL);
    nb = (got_data.size() < FL) ? got_data.size() : FL;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] e;
      e = (i < FD) ? 8'(i) : 8'(40 + i - FD);
      check("ovf beat", {16'd0, got_data[i]}, {16'd0, e, e});
      check("ovf tlast", {31'd0, got_last[i]}, (i == FL - 1) ? 32'd1 : 32'd0);
    end
    check("ovf done", ndone, 1);
    check("ovf busy", {31'd0, busy}, 32'd0);
    check("overflow sticky", {31'd0, overflow}, 32'd1);
    arm();
    check("overflow cleared on arm", {31'd0, overflow}, 32'd0);

    // reset during beat 3
    do_reset();
    cfg_mode = 2'd0;
    axis_tready = 1'b1;
    arm();
    for (int i = 0; i < 3; i++) adc_sample({8'(i), 8'(i)});
    adc_data = 16'h0303;
    adc_clk = 1'b1;
    tick(); tick(); tick();
    check("beat3 tvalid", {31'd0, axis_tvalid}, 32'd1);
    check("beat3 tdata", {16'd0, axis_tdata}, 32'h00000303);
    axi_areset = 1'b1;
    adc_clk = 1'b0;
    tick();
    check("mid reset tvalid", {31'd0, axis_tvalid}, 32'd0);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    axi_areset = 1'b0;
    repeat (4) tick();
    check("post reset tvalid", {31'd0, axis_tvalid}, 32'd0);
    nb = 0;
    foreach (got_last[i]) nb += got_last[i];
    check("abandoned frame tlast", nb, 0);

    // randomized frames against the reference model
    for (int it = 0; it < 6; it++) begin
      logic [1:0] m;
      int d;
      m = 2'($urandom_range(0, 2));
      d = $urandom_range(0, 3);
      smp_q.delete();
      for (int i = 0; i < (d + 1) * (FL + 12); i++) smp_q.push_back(16'($urandom));
      run_frame(m, d, 8'($urandom_range(8'h40, 8'hC0)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_mc.md
# adc_capture_mc

Multi-channel, parametrised ADC capture engine; the successor to the single-channel ADC streamer. Every `adc_clk` rising edge it samples `CHANNELS` packed ADC lanes and decimates the sample stream. It then waits for a software-armed trigger (free-run, level crossing or external) and streams exactly one `FRAME_LEN`-beat frame out through an internal FIFO on AXI4-Stream toward the CCU. It sits between the ADC socket / `adda_clk` divider and the CCU, in the `sys_clk` domain.

## Interface
Parameters:
- `CHANNELS`, 2: number of ADC lanes sampled together.
- `DATA_W`, 8: bits per lane.
- `FRAME_LEN`, 256: beats per frame (≥2).
- `FIFO_DEPTH`, 16: output FIFO entries (power of two).
- `DECIM_W`, 8: width of the decimation setting.

Ports:
- `axi_aclk` in 1: system clock.
- `axi_areset` in 1: reset, **synchronous, active-high**.
- `adc_clk` in 1: sample strobe from `adda_clk`; its rising edge is detected in the `axi_aclk` domain.
- `adc_data` in CHANNELS*DATA_W: lane *k* occupies bits [k*DATA_W +: DATA_W].
- `cfg_arm` in 1: single-cycle arm pulse.
- `cfg_mode` in 2: trigger mode. 0 free-run, 1 rising level, 2 falling level, 3 external.
- `cfg_level` in DATA_W: threshold, unsigned.
- `cfg_chan` in clog2(CHANNELS): lane whose value is compared against `cfg_level`.
- `cfg_decim` in DECIM_W: keep 1 of every `cfg_decim`+1 strobes.
- `ext_trig` in 1: asynchronous external trigger.
- `axis_tvalid` out 1; `axis_tready` in 1; `axis_tdata` out CHANNELS*DATA_W; `axis_tlast` out 1.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: one-cycle pulse when the last beat enters the FIFO.
- `overflow` out 1: sticky; cleared on arm.

## Operation
- **Strobe detection:** `adc_clk` is registered into `clk_d`; `strobe = adc_clk & ~clk_d`.
- **Sample register:** on `strobe`, `adc_data` is registered into `smp`.
- **Decimation:** a decimation counter counts strobes from 0 to `cfg_decim` and wraps. A sample is "kept" when the count equals 0. The counter is cleared on arm. `cfg_decim`=0 keeps every strobe.
- **FSM states: IDLE, ARMED, CAPTURE.**
  - IDLE: `cfg_arm` → ARMED. Arming clears `overflow`, the decimation counter, the beat counter and `prev_valid`.
  - ARMED, per kept sample, with *v* = lane `cfg_chan` of `smp`:
    - Mode 0 triggers on the first kept sample.
    - Mode 1 triggers when `prev_valid` && prev < `cfg_level` && *v* ≥ `cfg_level`.
    - Mode 2 triggers when `prev_valid` && prev ≥ `cfg_level` && *v* < `cfg_level`.
    - Mode 3 triggers on a kept sample coinciding with or following a rising edge of the synchronised `ext_trig`. The edge is latched while ARMED.
    - Non-triggering kept samples update prev and set `prev_valid`. The triggering sample is beat 0 of the frame, and the FSM moves to CAPTURE.
  - CAPTURE: each kept sample is written to the FIFO as one beat. Beat `FRAME_LEN`-1 is written with last=1 and pulses `done`, then the FSM moves to IDLE.
  - `cfg_arm` in ARMED or CAPTURE is ignored.
- **FIFO full on a write attempt:** the sample is dropped, `overflow` is set, and the beat counter does not advance. The frame therefore always has exactly `FRAME_LEN` beats.
- **Config sampling:** `cfg_*` inputs are sampled continuously and must be held stable while `busy`.
- **Reset mid-operation:** FSM → IDLE, FIFO emptied, counters cleared. A partially streamed frame is abandoned with no `tlast`.

## Timing
- **Reset values:** `axis_tvalid`=0, `axis_tdata`=0, `axis_tlast`=0, `busy`=0, `done`=0, `overflow`=0.
- **Latency:** cycle *t* is the first cycle with `adc_clk`=1 and `clk_d`=0.
  - `smp` is valid at *t*+1.
  - The trigger decision and FIFO write happen at *t*+2.
  - The earliest `axis_tvalid` is at *t*+3, because the FIFO output is registered.
- **AXI4-Stream:** a beat transfers when `tvalid` && `tready`. While `tvalid` is high and `tready` is low, `tdata` and `tlast` hold.
- **Throughput:** the FIFO sustains one read and one write per cycle. A simultaneous read and write when full is allowed, and is not an overflow.
- **External trigger synchroniser:** two flops, plus an edge-detect register.

## Configuration
- `ADC_CAPTURE_EXT_TRIG_EN` defined: mode 3 and the `ext_trig` synchroniser are present.
- Undefined: the synchroniser is removed, `ext_trig` is ignored, and mode 3 behaves exactly as mode 0.

## Structure
- Package `adc_capture_pkg`:
  - trigger-mode encoding constants (MODE_FREE, MODE_RISE, MODE_FALL, MODE_EXT);
  - FSM state encoding (ST_IDLE, ST_ARMED, ST_CAPTURE).
- Sub-module `sync_fifo`:
  - width CHANNELS*DATA_W+1, depth FIFO_DEPTH, registered output, full/empty flags;
  - reusable by the SPI blocks.

## Test plan
- **Free-run:** mode 0, decim 0, FRAME_LEN 8, ramp input 0..15, `tready`=1 → beats 0..7 (after arm), `tlast` on beat 7, one `done` pulse, `busy` low afterwards.
- **Rising level:** mode 1, level 0x80, chan 1, lane 1 sequence 0x10, 0x7F, 0x80, 0x90 → first beat carries lane1=0x80.
- **Falling level, no prior sample:** mode 2 with a falling crossing on the first kept sample after arm → no trigger until a second crossing.
- **Decimation:** decim 3 on a 0..31 ramp, mode 0 → beats 0, 4, 8, 12, …
- **Backpressure / overflow:** FIFO_DEPTH 16, `tready`=0 for 40 strobes → `overflow`=1 and 16 beats buffered. After `tready`=1, exactly FRAME_LEN beats total with `tlast` on the final one. Re-arm → `overflow`=0.
- **Reset mid-capture:** assert `axi_areset` during beat 3 → next cycle `tvalid`=0 and `busy`=0. With the macro undefined, mode 3 behaves as mode 0.
